// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: frame states,
// parity mode encodings and the smallest usable baud divisor.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  // A divisor below this would leave no cycle in which to pre-announce byte_done.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a byte FIFO and its UART transmitter consumer.
interface fifo_uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic                 fifo_nempty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_pop;

  modport master (
    output fifo_nempty,
    output fifo_data,
    input  fifo_pop
  );

  modport slave (
    input  fifo_nempty,
    input  fifo_data,
    output fifo_pop
  );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Loadable down-counter for bit timing; terminal count flags the last cycle of a bit.
module baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_value,
  output logic [DIV_WIDTH-1:0] count,
  output logic                 tc
);

  // Holds at zero once expired so an idle transmitter sees a steady terminal count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - DIV_WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and serialises them as UART frames (start, data LSB first,
// optional parity, 1 or 2 stop bits), chaining frames back-to-back while data remains.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  fifo_uart_tx_if.slave        fif,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done
);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DIV_WIDTH-1:0] div_q, div_n;
  logic [1:0]           par_q, par_n;
  logic                 stop2_q, stop2_n;
  logic                 parity_q, parity_n;
  logic                 pop_q, pop_n;
  logic                 tx_n, done_n;

  logic                 load;
  logic [DIV_WIDTH-1:0] load_value;
  logic [DIV_WIDTH-1:0] count;
  logic                 tc;

  logic [DIV_WIDTH-1:0] clamp_div;
  logic                 parity_on;
  logic                 launch_pt;

  baud_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc)
  );

  assign clamp_div    = (baud_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : baud_div;
  assign parity_on    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign launch_pt    = (state == ST_IDLE) ||
                        ((state == ST_STOP) && tc && (bit_cnt == 4'd0));
  assign fif.fifo_pop = pop_q;

  // Next-state and next-output logic; a launch overrides whatever the frame would do next.
  always_comb begin
    state_n    = state;
    shift_n    = shift_reg;
    bit_cnt_n  = bit_cnt;
    div_n      = div_q;
    par_n      = par_q;
    stop2_n    = stop2_q;
    parity_n   = parity_q;
    pop_n      = 1'b0;
    tx_n       = tx;
    load       = 1'b0;
    load_value = div_q - DIV_WIDTH'(1);
    done_n     = (state == ST_STOP) && (bit_cnt == 4'd0) && (count == DIV_WIDTH'(1));

    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
      end
      ST_START: begin
        if (tc) begin
          state_n   = ST_DATA;
          tx_n      = shift_reg[0];
          bit_cnt_n = 4'(DATA_BITS - 1);
          load      = 1'b1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          load = 1'b1;
          if (bit_cnt != 4'd0) begin
            shift_n   = shift_reg >> 1;
            tx_n      = shift_reg[1];
            bit_cnt_n = bit_cnt - 4'd1;
          end else if (parity_on) begin
            state_n = ST_PARITY;
            tx_n    = parity_q;
          end else begin
            state_n   = ST_STOP;
            tx_n      = 1'b1;
            bit_cnt_n = {3'd0, stop2_q};
          end
        end
      end
      ST_PARITY: begin
        if (tc) begin
          state_n   = ST_STOP;
          tx_n      = 1'b1;
          bit_cnt_n = {3'd0, stop2_q};
          load      = 1'b1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          if (bit_cnt != 4'd0) begin
            bit_cnt_n = bit_cnt - 4'd1;
            load      = 1'b1;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (launch_pt && enable && fif.fifo_nempty) begin
      state_n    = ST_START;
      shift_n    = fif.fifo_data;
      div_n      = clamp_div;
      par_n      = parity_mode;
      stop2_n    = stop2;
      parity_n   = (^fif.fifo_data) ^ (parity_mode == PAR_ODD);
      pop_n      = 1'b1;
      tx_n       = 1'b0;
      load       = 1'b1;
      load_value = clamp_div - DIV_WIDTH'(1);
    end
  end

  // All outputs are registered so the serial line never glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_q     <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      parity_q  <= 1'b0;
      pop_q     <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_cnt_n;
      div_q     <= div_n;
      par_q     <= par_n;
      stop2_q   <= stop2_n;
      parity_q  <= parity_n;
      pop_q     <= pop_n;
      tx        <= tx_n;
      busy      <= (state_n != ST_IDLE);
      byte_done <= done_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-based frame model predicts tx/pop/busy/done
// every cycle, and directed scenarios pin frame shapes with hand-computed constants.
module tb_fifo_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic        tx, busy, byte_done;

  fifo_uart_tx_if #(.DATA_BITS(8)) fif ();

  fifo_uart_tx #(
    .DATA_BITS(8),
    .DIV_WIDTH(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .fif         (fif),
    .tx          (tx),
    .busy        (busy),
    .byte_done   (byte_done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit run_checks = 1'b0;

  logic [7:0] fq[$];
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'b1000;

  int           mon_cyc, mon_first_busy, mon_last_busy, mon_busy_cnt, mon_tx_low;
  int           pop_at[$];
  int           done_at[$];
  logic [127:0] hist;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic fifo_sync();
    fif.fifo_nempty = (fq.size() != 0);
    fif.fifo_data   = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_sync();
  endtask

  task automatic apply_stimulus(input logic en, input logic [15:0] d, input logic [1:0] pm, input logic s2);
    enable      = en;
    baud_div    = d;
    parity_mode = pm;
    stop2       = s2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic mon_clear();
    mon_cyc = 0;
    mon_first_busy = -1;
    mon_last_busy = -1;
    mon_busy_cnt = 0;
    mon_tx_low = 0;
    pop_at.delete();
    done_at.delete();
    hist = '0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (done_at.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    #2;
    check_output({name, " done count"}, 64'(done_at.size()), 64'(n));
  endtask

  // Reference frame: list of line levels, each stretched over the clamped divisor.
  function automatic void build_frame(input logic [7:0] b, input logic [15:0] div,
                                      input logic [1:0] pm, input logic s2);
    int   d, total, idx;
    logic bits[$];
    d = (div < 16'd2) ? 2 : int'(div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pm == 2'b01) bits.push_back(^b);
    else if (pm == 2'b10) bits.push_back(~^b);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    total = bits.size() * d;
    idx = 0;
    foreach (bits[k]) begin
      for (int c = 0; c < d; c++) begin
        exp_q.push_back({bits[k], idx == 0, 1'b1, idx == total - 1});
        idx++;
      end
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      cur = 4'b1000;
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && enable && fif.fifo_nempty)
        build_frame(fif.fifo_data, baud_div, parity_mode, stop2);
      cur = (exp_q.size() != 0) ? exp_q[0] : 4'b1000;
    end
  end

  always @(negedge clock) begin
    if (!reset && run_checks)
      check_output($sformatf("cycle@%0t {tx,pop,busy,done}", $time),
                   64'({tx, fif.fifo_pop, busy, byte_done}), 64'(cur));
    if (fif.fifo_pop && fq.size() != 0) begin
      void'(fq.pop_front());
      fifo_sync();
    end
    mon_cyc++;
    if (busy) begin
      if (mon_first_busy < 0) mon_first_busy = mon_cyc;
      mon_last_busy = mon_cyc;
      mon_busy_cnt++;
      hist = {hist[126:0], tx};
    end
    if (fif.fifo_pop) pop_at.push_back(mon_cyc);
    if (byte_done) done_at.push_back(mon_cyc);
    if (!tx) mon_tx_low++;
  end

  initial begin
    fif.fifo_nempty = 1'b0;
    fif.fifo_data   = 8'h00;
    mon_clear();
    #1 reset = 1'b1;
    #2;
    check_output("reset tx", 64'(tx), 64'(1));
    check_output("reset busy", 64'(busy), 64'(0));
    check_output("reset pop", 64'(fif.fifo_pop), 64'(0));
    check_output("reset done", 64'(byte_done), 64'(0));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    run_checks = 1'b1;
    wait_cycles(2);

    // single byte 0x55, 8N1, 4 cycles per bit
    apply_stimulus(1'b0, 16'd4, 2'b00, 1'b0);
    push_byte(8'h55);
    mon_clear();
    enable = 1'b1;
    wait_dones(1, 200, "single");
    wait_cycles(3);
    enable = 1'b0;
    check_output("single busy cycles", 64'(mon_busy_cnt), 64'd40);
    check_output("single waveform", 64'(hist[39:0]), 64'h0F0F0F0F0F);
    check_output("single pop count", 64'(pop_at.size()), 64'd1);
    if (pop_at.size() == 1) check_output("single pop cycle", 64'(pop_at[0]), 64'(mon_first_busy));
    check_output("single done cycle", 64'(done_at[0] - mon_first_busy + 1), 64'd40);

    // back-to-back frames
    push_byte(8'hA3);
    push_byte(8'h0F);
    apply_stimulus(1'b0, 16'd3, 2'b00, 1'b0);
    mon_clear();
    enable = 1'b1;
    wait_dones(2, 300, "b2b");
    wait_cycles(3);
    enable = 1'b0;
    check_output("b2b busy cycles", 64'(mon_busy_cnt), 64'd60);
    check_output("b2b contiguous span", 64'(mon_last_busy - mon_first_busy + 1), 64'd60);
    check_output("b2b pop count", 64'(pop_at.size()), 64'd2);
    if (pop_at.size() == 2) check_output("b2b pop spacing", 64'(pop_at[1] - pop_at[0]), 64'd30);
    check_output("b2b idle tx", 64'(tx), 64'd1);
    check_output("b2b idle busy", 64'(busy), 64'd0);

    // even parity, one stop bit
    push_byte(8'h07);
    apply_stimulus(1'b0, 16'd2, 2'b01, 1'b0);
    mon_clear();
    enable = 1'b1;
    wait_dones(1, 200, "even");
    wait_cycles(2);
    enable = 1'b0;
    check_output("even length", 64'(mon_busy_cnt), 64'd22);
    check_output("even waveform", 64'(hist[21:0]), 64'h0FC00F);

    // odd parity, two stop bits
    push_byte(8'h07);
    apply_stimulus(1'b0, 16'd2, 2'b10, 1'b1);
    mon_clear();
    enable = 1'b1;
    wait_dones(1, 200, "odd");
    wait_cycles(2);
    enable = 1'b0;
    check_output("odd length", 64'(mon_busy_cnt), 64'd24);
    check_output("odd waveform", 64'(hist[23:0]), 64'h3F000F);

    // divisor clamp and mid-frame divisor change
    push_byte(8'h96);
    push_byte(8'h3C);
    apply_stimulus(1'b0, 16'd0, 2'b00, 1'b0);
    mon_clear();
    enable = 1'b1;
    wait_cycles(5);
    baud_div = 16'd8;
    wait_dones(2, 400, "clamp");
    wait_cycles(2);
    enable = 1'b0;
    check_output("clamp first frame", 64'(done_at[0] - mon_first_busy + 1), 64'd20);
    if (done_at.size() == 2) check_output("clamp second frame", 64'(done_at[1] - done_at[0]), 64'd80);

    // enable low with data waiting, then enable dropped mid-frame
    push_byte(8'hC5);
    push_byte(8'h81);
    apply_stimulus(1'b0, 16'd2, 2'b00, 1'b0);
    mon_clear();
    wait_cycles(50);
    check_output("disabled pops", 64'(pop_at.size()), 64'd0);
    check_output("disabled tx low cycles", 64'(mon_tx_low), 64'd0);
    enable = 1'b1;
    wait_cycles(5);
    enable = 1'b0;
    wait_cycles(60);
    check_output("drop enable pops", 64'(pop_at.size()), 64'd1);
    check_output("drop enable busy cycles", 64'(mon_busy_cnt), 64'd20);
    mon_clear();
    enable = 1'b1;
    wait_dones(1, 100, "drain");
    wait_cycles(3);
    mon_clear();
    wait_cycles(100);
    check_output("empty busy cycles", 64'(mon_busy_cnt), 64'd0);
    check_output("empty pops", 64'(pop_at.size()), 64'd0);
    enable = 1'b0;

    // asynchronous reset in the middle of the data bits
    push_byte(8'h3C);
    push_byte(8'h5A);
    apply_stimulus(1'b1, 16'd4, 2'b00, 1'b0);
    wait_cycles(10);
    #1 reset = 1'b1;
    #1;
    check_output("midreset tx", 64'(tx), 64'd1);
    check_output("midreset busy", 64'(busy), 64'd0);
    check_output("midreset pop", 64'(fif.fifo_pop), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_output("relaunch pop", 64'(fif.fifo_pop), 64'd1);
    check_output("relaunch tx", 64'(tx), 64'd0);
    mon_clear();
    wait_dones(1, 100, "relaunch");
    enable = 1'b0;
    wait_cycles(2);

    // randomized traffic checked by the frame model
    for (int it = 0; it < 300; it++) begin
      if (fq.size() < 4 && $urandom_range(0, 2) != 0) push_byte(8'($urandom));
      apply_stimulus($urandom_range(0, 4) != 0, 16'($urandom_range(0, 5)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      wait_cycles($urandom_range(1, 30));
    end
    enable = 1'b1;
    begin
      int k;
      k = 0;
      while ((fq.size() != 0 || busy) && k < 3000) begin
        @(posedge clock);
        k++;
      end
      #2;
    end
    check_output("random drain busy", 64'(busy), 64'd0);
    check_output("random drain fifo", 64'(fq.size()), 64'd0);
    enable = 1'b0;
    wait_cycles(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
